// File: rtl/alu_issue_decode.sv
// Decode/issue stage: turns one RV32I/RV32M instruction plus its operands
// into an ALU op code and operands. The decoded bundle sits in an output
// register behind a valid/ready handshake toward the execute stage.
module alu_issue_decode #(
  parameter int DATA_WIDTH = 32,
  parameter int XLEN_SHAMT = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [31:0]           i_instr,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [7:0]            o_alu_op,
  output logic [DATA_WIDTH-1:0] o_a,
  output logic [DATA_WIDTH-1:0] o_b,
  output logic [4:0]            o_rd,
  output logic                  o_we,
  output logic                  o_illegal
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h11;
  localparam logic [7:0] OP_SUB = 8'h12;
  localparam logic [7:0] OP_MUL = 8'h13;
  localparam logic [7:0] OP_DIV = 8'h14;
  localparam logic [7:0] OP_MOD = 8'h15;
  localparam logic [7:0] OP_AND = 8'h21;
  localparam logic [7:0] OP_OR  = 8'h22;
  localparam logic [7:0] OP_XOR = 8'h23;
  localparam logic [7:0] OP_SLT = 8'h31;
  localparam logic [7:0] OP_SLL = 8'h33;
  localparam logic [7:0] OP_SRL = 8'h34;
  localparam logic [7:0] OP_SRA = 8'h35;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;
  logic       unused_rs1_field;

  assign opcode           = i_instr[6:0];
  assign funct3           = i_instr[14:12];
  assign funct7           = i_instr[31:25];
  assign rd_field         = i_instr[11:7];
  // Register indices are resolved upstream; only their values arrive here.
  assign unused_rs1_field = ^i_instr[19:15];

  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_shamt;
  logic [DATA_WIDTH-1:0] imm_u;

  assign imm_i     = {{(DATA_WIDTH-12){i_instr[31]}}, i_instr[31:20]};
  assign imm_shamt = {{(DATA_WIDTH-XLEN_SHAMT){1'b0}}, i_instr[20 +: XLEN_SHAMT]};
  assign imm_u     = {i_instr[31:12], 12'b0};

  // Registered bundle
  logic                  valid_q;
  logic [7:0]            alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [4:0]            rd_q;
  logic                  we_q, we_d;
  logic                  illegal_q, illegal_d;

  logic [7:0]            dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b;
  logic                  dec_legal;
  logic                  accept;

  // Flush blocks acceptance in the same cycle it discards the held bundle.
  assign o_ready = ~i_flush & (~valid_q | i_ready);
  assign accept  = i_valid & o_ready;

  // Instruction decode; anything not recognised falls through as illegal.
  always_comb begin
    dec_op    = OP_NOP;
    dec_a     = '0;
    dec_b     = '0;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_a = i_rs1_data;
        dec_b = i_rs2_data;
        case (funct7)
          F7_BASE: begin
            dec_legal = 1'b1;
            case (funct3)
              3'b000:  dec_op = OP_ADD;
              3'b001:  dec_op = OP_SLL;
              3'b010:  dec_op = OP_SLT;
              3'b100:  dec_op = OP_XOR;
              3'b101:  dec_op = OP_SRL;
              3'b110:  dec_op = OP_OR;
              3'b111:  dec_op = OP_AND;
              default: dec_legal = 1'b0; // SLTU has no ALU op
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000) begin
              dec_op    = OP_SUB;
              dec_legal = 1'b1;
            end else if (funct3 == 3'b101) begin
              dec_op    = OP_SRA;
              dec_legal = 1'b1;
            end
          end
          F7_MUL: begin
            // Only the unsigned divide/remainder forms are supported.
            dec_legal = 1'b1;
            case (funct3)
              3'b000:  dec_op = OP_MUL;
              3'b101:  dec_op = OP_DIV;
              3'b111:  dec_op = OP_MOD;
              default: dec_legal = 1'b0;
            endcase
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec_a     = i_rs1_data;
        dec_b     = imm_i;
        dec_legal = 1'b1;
        case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b010: dec_op = OP_SLT;
          3'b100: dec_op = OP_XOR;
          3'b110: dec_op = OP_OR;
          3'b111: dec_op = OP_AND;
          3'b001: begin
            dec_op    = OP_SLL;
            dec_b     = imm_shamt;
            dec_legal = (funct7 == F7_BASE);
          end
          3'b101: begin
            dec_op    = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            dec_b     = imm_shamt;
            dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: dec_legal = 1'b0; // SLTIU
        endcase
      end
      OPC_LUI: begin
        dec_op    = OP_ADD;
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op    = OP_ADD;
        dec_a     = i_pc;
        dec_b     = imm_u;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal bundles still flow through, but as a harmless NOP with zero operands.
  always_comb begin
    alu_op_d  = dec_legal ? dec_op : OP_NOP;
    a_d       = dec_legal ? dec_a : '0;
    b_d       = dec_legal ? dec_b : '0;
    we_d      = dec_legal & (rd_field != 5'd0);
    illegal_d = ~dec_legal;
  end

  // Output register: flush beats accept, accept beats drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      alu_op_q  <= OP_NOP;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else if (i_flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      alu_op_q  <= alu_op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_field;
      we_q      <= we_d;
      illegal_q <= illegal_d;
    end else if (i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign o_valid   = valid_q;
  assign o_alu_op  = alu_op_q;
  assign o_a       = a_q;
  assign o_b       = b_q;
  assign o_rd      = rd_q;
  assign o_we      = we_q;
  assign o_illegal = illegal_q;

endmodule
